// File: rtl/prog_cfg_pkg.sv
// prog_cfg_pkg: shared definitions for the programming-chain loader and the
// host-interface bridge that issues commands to it.
//   CMD_LOAD / CMD_READBACK : encodings of the one-bit command opcode
//   state_t                 : loader FSM state encoding
//   chunk_bits()            : number of bits the next byte contributes
package prog_cfg_pkg;

  localparam logic CMD_LOAD     = 1'b0;
  localparam logic CMD_READBACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_FETCH = 3'd1,
    ST_LOAD_SHIFT = 3'd2,
    ST_RB_SHIFT   = 3'd3,
    ST_RB_EMIT    = 3'd4,
    ST_FINISH     = 3'd5
  } state_t;

  // Bits carried by the next byte: a full byte, or what is left of the chain.
  function automatic logic [3:0] chunk_bits(input int unsigned remaining);
    if (remaining >= 32'd8) begin
      return 4'd8;
    end else begin
      return 4'(remaining);
    end
  endfunction

endpackage

// File: rtl/prog_chain_loader_if.sv
// prog_chain_loader_if: host-side handshakes of the chain loader.
//   cmd_*  : command request (cmd_op 0 = LOAD, 1 = READBACK)
//   din_*  : load byte stream, LSB shifted first
//   dout_* : readback byte stream, bit 0 = earliest chain bit
// master = configuration host, slave = loader.
interface prog_chain_loader_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] din_data;
  logic       dout_valid;
  logic       dout_ready;
  logic [7:0] dout_data;

  modport master (
    output cmd_valid, cmd_op, din_valid, din_data, dout_ready,
    input  cmd_ready, din_ready, dout_valid, dout_data
  );

  modport slave (
    input  cmd_valid, cmd_op, din_valid, din_data, dout_ready,
    output cmd_ready, din_ready, dout_valid, dout_data
  );
endinterface

// File: rtl/prog_byte_serdes.sv
// prog_byte_serdes: 8-bit shift buffer with a bit counter, shared by the
// serialiser (load) and deserialiser (readback) paths.
//   clear          : zero buffer and counter (highest priority)
//   load/load_data/load_cnt : parallel load, counter = bits to send
//   shift          : buffer >>= 1, counter--; ser_bit is buffer bit 0
//   capture/cap_bit: write cap_bit at position counter, counter++
//   data, cnt      : current buffer and counter
module prog_byte_serdes (
  input  logic       prog_clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic [3:0] load_cnt,
  input  logic       shift,
  input  logic       capture,
  input  logic       cap_bit,
  output logic [7:0] data,
  output logic [3:0] cnt,
  output logic       ser_bit
);

  logic [7:0] buf_r;
  logic [3:0] cnt_r;

  // Buffer and counter update; clear wins so a fresh byte always starts at 0.
  always_ff @(posedge prog_clk or posedge rst) begin
    if (rst) begin
      buf_r <= 8'h00;
      cnt_r <= 4'd0;
    end else if (clear) begin
      buf_r <= 8'h00;
      cnt_r <= 4'd0;
    end else if (load) begin
      buf_r <= load_data;
      cnt_r <= load_cnt;
    end else if (shift) begin
      buf_r <= {1'b0, buf_r[7:1]};
      cnt_r <= cnt_r - 4'd1;
    end else if (capture) begin
      buf_r[cnt_r[2:0]] <= cap_bit;
      cnt_r             <= cnt_r + 4'd1;
    end
  end

  assign data    = buf_r;
  assign cnt     = cnt_r;
  assign ser_bit = buf_r[0];

endmodule

// File: rtl/prog_chain_loader.sv
// prog_chain_loader: shifts a byte-stream bitstream into a daisy chain of
// programmable muxes and reads it back non-destructively by recirculation.
//   prog_clk, rst : clock (shared with the chain) and async active-high reset
//   bus           : cmd / din / dout handshakes (slave side)
//   chain_en      : chain shift enable (prog_en)
//   chain_in      : serial data into the chain head (prog_in)
//   chain_out     : serial data from the chain tail (prog_out)
//   busy          : command in progress
//   done          : one-cycle pulse at command completion
//   cfg_valid     : chain holds a complete loaded bitstream
module prog_chain_loader
  import prog_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 prog_clk,
  input  logic                 rst,
  prog_chain_loader_if.slave   bus,
  output logic                 chain_en,
  output logic                 chain_in,
  input  logic                 chain_out,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_valid
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] remaining_r;
  logic             op_r;
  logic             cfg_valid_r;
  logic             rem_load_s, rem_dec_s, rem_last_s;
  logic             sd_clear_s, sd_load_s, sd_shift_s, sd_capture_s;
  logic [3:0]       sd_load_cnt_s;
  logic [7:0]       sd_data_s;
  logic [3:0]       sd_cnt_s;
  logic             sd_bit_s;
  logic             chain_in_s;

  assign rem_last_s = (remaining_r == CNT_W'(1));

  prog_byte_serdes u_serdes (
    .prog_clk  (prog_clk),
    .rst       (rst),
    .clear     (sd_clear_s),
    .load      (sd_load_s),
    .load_data (bus.din_data),
    .load_cnt  (sd_load_cnt_s),
    .shift     (sd_shift_s),
    .capture   (sd_capture_s),
    .cap_bit   (chain_out),
    .data      (sd_data_s),
    .cnt       (sd_cnt_s),
    .ser_bit   (sd_bit_s)
  );

  // FSM state register.
  always_ff @(posedge prog_clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Remaining-bit counter and latched opcode of the running command.
  always_ff @(posedge prog_clk or posedge rst) begin
    if (rst) begin
      remaining_r <= CNT_W'(0);
      op_r        <= CMD_LOAD;
    end else if (rem_load_s) begin
      remaining_r <= CHAIN_LEN_C;
      op_r        <= bus.cmd_op;
    end else if (rem_dec_s) begin
      remaining_r <= remaining_r - CNT_W'(1);
    end
  end

  // cfg_valid drops when a LOAD starts and rises only when it completes.
  always_ff @(posedge prog_clk or posedge rst) begin
    if (rst) begin
      cfg_valid_r <= 1'b0;
    end else if (rem_load_s && (bus.cmd_op == CMD_LOAD)) begin
      cfg_valid_r <= 1'b0;
    end else if ((state_r == ST_FINISH) && (op_r == CMD_LOAD)) begin
      cfg_valid_r <= 1'b1;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_s       = state_r;
    rem_load_s    = 1'b0;
    rem_dec_s     = 1'b0;
    sd_clear_s    = 1'b0;
    sd_load_s     = 1'b0;
    sd_shift_s    = 1'b0;
    sd_capture_s  = 1'b0;
    sd_load_cnt_s = 4'd0;
    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          rem_load_s = 1'b1;
          sd_clear_s = 1'b1;
          if (bus.cmd_op == CMD_READBACK) begin
            state_s = ST_RB_SHIFT;
          end else begin
            state_s = ST_LOAD_FETCH;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD_FETCH: begin
        if (bus.din_valid) begin
          sd_load_s     = 1'b1;
          sd_load_cnt_s = chunk_bits(32'(remaining_r));
          state_s       = ST_LOAD_SHIFT;
        end else begin
          state_s = ST_LOAD_FETCH;
        end
      end
      ST_LOAD_SHIFT: begin
        sd_shift_s = 1'b1;
        rem_dec_s  = 1'b1;
        // Last bit of this byte goes out this cycle.
        if (sd_cnt_s == 4'd1) begin
          if (rem_last_s) begin
            state_s = ST_FINISH;
          end else begin
            state_s = ST_LOAD_FETCH;
          end
        end else begin
          state_s = ST_LOAD_SHIFT;
        end
      end
      ST_RB_SHIFT: begin
        sd_capture_s = 1'b1;
        rem_dec_s    = 1'b1;
        // Byte fills (8th capture) or chain exhausted after this capture.
        if ((sd_cnt_s == 4'd7) || rem_last_s) begin
          state_s = ST_RB_EMIT;
        end else begin
          state_s = ST_RB_SHIFT;
        end
      end
      ST_RB_EMIT: begin
        if (bus.dout_ready) begin
          sd_clear_s = 1'b1;
          if (remaining_r == CNT_W'(0)) begin
            state_s = ST_FINISH;
          end else begin
            state_s = ST_RB_SHIFT;
          end
        end else begin
          state_s = ST_RB_EMIT;
        end
      end
      ST_FINISH: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Serial chain input: buffered load bit, or tail recirculated on readback.
  always_comb begin
    chain_in_s = 1'b0;
    case (state_r)
      ST_LOAD_SHIFT: chain_in_s = sd_bit_s;
      ST_RB_SHIFT:   chain_in_s = chain_out;
      default:       chain_in_s = 1'b0;
    endcase
  end

  assign chain_in       = chain_in_s;
  assign chain_en       = (state_r == ST_LOAD_SHIFT) || (state_r == ST_RB_SHIFT);
  assign busy           = (state_r != ST_IDLE);
  assign done           = (state_r == ST_FINISH);
  assign cfg_valid      = cfg_valid_r;
  assign bus.cmd_ready  = (state_r == ST_IDLE);
  assign bus.din_ready  = (state_r == ST_LOAD_FETCH);
  assign bus.dout_valid = (state_r == ST_RB_EMIT);
  assign bus.dout_data  = (state_r == ST_RB_EMIT) ? sd_data_s : 8'h00;

endmodule
